fibo_stream: RTL and testbench
==============================

FIBO_STREAM -- requirements
Module: fibo_stream

Interface
REQ-001 Parameter WIDTH, default 32: bit width of every sequence term.
REQ-002 Parameter CNT_W, default 8: width of term count and index.
REQ-003 Parameter OVF_MODE, default 0: overflow behaviour; 0 = stop, 1 = wrap.
REQ-004 Ports:
- clk  in  1  clock; every register updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a new sequence; sampled only in IDLE.
- seed_a  in  WIDTH  term 0; latched on an accepted start.
- seed_b  in  WIDTH  term 1; latched on an accepted start.
- count  in  CNT_W  number of terms to emit; latched on an accepted start.
- ready  in  1  consumer can accept the current term.
- valid  out  1  value holds a term.
- value  out  WIDTH  current term.
- index  out  CNT_W  position of the current term, starting at 0.
- last  out  1  current term is the final requested term.
- busy  out  1  a sequence is in progress.
- done  out  1  one-cycle pulse when a sequence ends.
- overflow  out  1  sticky flag: a term exceeded WIDTH.

Function
REQ-005 The block SHALL have the states IDLE and RUN.
REQ-006 In IDLE, start=1 with count!=0 SHALL do the following:
- latch seeds and count;
- set index=0, busy=1 and overflow=0;
- enter RUN, with valid=1 and value=seed_a on the next cycle.
REQ-007 In IDLE, start=1 with count=0 SHALL be ignored: no state change and no done pulse.
REQ-008 In RUN, start SHALL be ignored.
REQ-009 A transfer SHALL occur on a rising edge where valid=1 and ready=1.
REQ-010 While valid=1 and ready=0, value, index and last SHALL hold stable.
REQ-011 On each transfer, the block SHALL update its term registers as follows:
- a<=b;
- b<=a+b, computed at WIDTH+1 bits with the carry kept as a per-term overflow mark;
- index<=index+1.
REQ-012 last SHALL equal valid && (index==count-1), and SHALL be combinational from registers.
REQ-013 After the transfer of the term flagged last, the next cycle SHALL have valid=0, busy=0 and done=1, with the state back in IDLE.
REQ-014 An overflow mark SHALL propagate with its term from b to a.
REQ-015 When a marked term would next be presented and OVF_MODE=0, the block SHALL NOT present the term (valid=0), SHALL set overflow=1, SHALL pulse done, and SHALL return to IDLE.
REQ-016 When a marked term is presented and OVF_MODE=1, value SHALL be the sum modulo 2^WIDTH, and overflow SHALL be set and held until the next accepted start.
REQ-017 Once set, a mark SHALL make every later term marked.
REQ-018 Minimum latency SHALL be 1 cycle from start to the first valid.
REQ-019 Throughput SHALL be 1 term per cycle while ready=1.
REQ-020 done and a new start SHALL be able to coincide; start on the cycle done=1 SHALL be accepted because the state is IDLE.
REQ-021 index SHALL NOT wrap within a sequence, since count <= 2^CNT_W-1.

Reset
REQ-022 rst=0 SHALL immediately force the following, independent of clk and valid during a transfer:
- state=IDLE;
- valid, busy, done, last and overflow = 0;
- value, index and the term registers = 0.
REQ-023 After rst returns to 1, the block SHALL require a new start; no sequence resumes.

Structure
REQ-024 A shared package fibo_pkg SHALL hold:
- the state enum (IDLE, RUN);
- the OVF_STOP=0 and OVF_WRAP=1 constants.
REQ-025 The adder SHALL be the sub-module fibo_step: WIDTH-parameterised, inputs a, b and the two marks, outputs sum and mark.
REQ-026 The FSM, handshake and counters SHALL reside in fibo_stream; there are no other sub-modules.

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Basic run: seeds 0/1, count=13, ready=1 -> values 0,1,1,2,3,5,8,13,21,34,55,89,144 on consecutive cycles; last with 144; done next cycle; overflow=0.
- Back-pressure: same run with ready toggling 1,0,0,1,... -> same value order; value/index stable through every ready=0 cycle; no term lost or duplicated.
- Stop on overflow: WIDTH=8, OVF_MODE=0, seeds 0/1, count=20 -> 14 terms, 0..233 with index 13 last emitted; last never asserted; then done=1 and overflow=1 with no valid term.
- Wrap on overflow: WIDTH=8, OVF_MODE=1, seeds 0/1, count=16 -> index 14 value 121 (377 mod 256) and overflow=1; index 15 value 98 (610 mod 256); last on index 15.
- Ignored starts: start with count=0 in IDLE -> no busy and no done; start during RUN -> sequence unchanged; start on the done cycle -> new sequence begins the next cycle.
- Reset mid-run: rst=0 asynchronously at index 5 -> all outputs 0 immediately; after rst=1, outputs stay idle until the next start.

Source files
------------

// File: rtl/fibo_pkg.sv
// Shared types and constants for the Fibonacci stream generator.
package fibo_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } state_e;

  localparam int unsigned OVF_STOP = 0;
  localparam int unsigned OVF_WRAP = 1;

endpackage

// File: rtl/fibo_step.sv
// One Fibonacci step: sum of two terms with a sticky overflow mark.
module fibo_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             a_mark_i,
  input  logic             b_mark_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             mark_o
);

  logic [WIDTH:0] full;

  assign full   = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o  = full[WIDTH-1:0];
  // Any marked operand taints the result, so once set every later term stays marked.
  assign mark_o = full[WIDTH] | a_mark_i | b_mark_i;

endmodule

// File: rtl/fibo_stream.sv
// Streams a Fibonacci-like sequence from two seeds over a valid/ready handshake.
module fibo_stream
  import fibo_pkg::*;
#(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned OVF_MODE = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] seed_a_i,
  input  logic [WIDTH-1:0] seed_b_i,
  input  logic [CNT_W-1:0] count_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] value_o,
  output logic [CNT_W-1:0] index_o,
  output logic             last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             overflow_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             am_q, am_d, bm_q, bm_d;
  logic [CNT_W-1:0] idx_q, idx_d, cnt_q, cnt_d;
  logic             valid_q, valid_d, busy_q, busy_d, done_q, done_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] sum;
  logic             sum_mark;
  logic             is_last;

  fibo_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .a_i      (a_q),
    .b_i      (b_q),
    .a_mark_i (am_q),
    .b_mark_i (bm_q),
    .sum_o    (sum),
    .mark_o   (sum_mark)
  );

  assign is_last = valid_q && (idx_q == cnt_q - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    am_d    = am_q;
    bm_d    = bm_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    unique case (state_q)
      StIdle: begin
        if (start_i && (count_i != '0)) begin
          state_d = StRun;
          a_d     = seed_a_i;
          b_d     = seed_b_i;
          am_d    = 1'b0;
          bm_d    = 1'b0;
          idx_d   = '0;
          cnt_d   = count_i;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          ovf_d   = 1'b0;
        end
      end
      StRun: begin
        if (valid_q && ready_i) begin
          if (is_last) begin
            state_d = StIdle;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else if (bm_q && (OVF_MODE == OVF_STOP)) begin
            // The next term does not fit: end the sequence instead of presenting it.
            state_d = StIdle;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            ovf_d   = 1'b1;
          end else begin
            a_d   = b_q;
            b_d   = sum;
            am_d  = bm_q;
            bm_d  = sum_mark;
            idx_d = idx_q + CNT_W'(1);
            if (bm_q) begin
              ovf_d = 1'b1;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      am_q    <= am_d;
      bm_q    <= bm_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign valid_o    = valid_q;
  assign value_o    = a_q;
  assign index_o    = idx_q;
  assign last_o     = is_last;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_fibo_stream.sv
// Scoreboard bench: an 8-bit stop-mode instance (0) and wrap-mode instance (1) share stimulus.
module tb_fibo_stream;
  import fibo_pkg::*;

  typedef struct {
    logic [7:0] v;
    logic [7:0] idx;
    logic       last;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] seed_a = '0, seed_b = '0, count = '0;
  logic       ready = 1'b1;
  logic [1:0] valid, last, busy, done, ovf;
  logic [7:0] value [2];
  logic [7:0] index [2];

  int n_cmp = 0;
  int n_err = 0;

  exp_t q  [2][$];
  bit   dq [2][$];

  // Fibonacci terms 0..19 modulo 256, worked out by hand.
  logic [7:0] tab [20] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13, 8'd21, 8'd34,
                           8'd55, 8'd89, 8'd144, 8'd233, 8'd121, 8'd98, 8'd219, 8'd61,
                           8'd24, 8'd85};

  always #5 clk = ~clk;

  fibo_stream #(.WIDTH(8), .CNT_W(8), .OVF_MODE(OVF_STOP)) u_stop (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .seed_a_i(seed_a), .seed_b_i(seed_b),
    .count_i(count), .ready_i(ready), .valid_o(valid[0]), .value_o(value[0]),
    .index_o(index[0]), .last_o(last[0]), .busy_o(busy[0]), .done_o(done[0]),
    .overflow_o(ovf[0])
  );

  fibo_stream #(.WIDTH(8), .CNT_W(8), .OVF_MODE(OVF_WRAP)) u_wrap (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .seed_a_i(seed_a), .seed_b_i(seed_b),
    .count_i(count), .ready_i(ready), .valid_o(valid[1]), .value_o(value[1]),
    .index_o(index[1]), .last_o(last[1]), .busy_o(busy[1]), .done_o(done[1]),
    .overflow_o(ovf[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected stream for seeds 0/1: stop mode cuts off before the first 9-bit term.
  task automatic push_fib(input int cnt);
    int n;
    n = (cnt < 14) ? cnt : 14;
    for (int i = 0; i < n; i++) q[0].push_back('{tab[i], 8'(i), i == cnt - 1, 1'b0});
    dq[0].push_back(cnt > 14);
    for (int i = 0; i < cnt; i++) q[1].push_back('{tab[i], 8'(i), i == cnt - 1, i >= 14});
    dq[1].push_back(cnt > 14);
  endtask

  task automatic push_both(input logic [7:0] v, input logic [7:0] i, input logic l);
    for (int k = 0; k < 2; k++) q[k].push_back('{v, i, l, 1'b0});
  endtask

  task automatic start_seq(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    start = 1'b1; seed_a = a; seed_b = b; count = c;
    tick();
    start = 1'b0;
    check("first valid latency", {30'd0, valid}, 32'd3);
  endtask

  task automatic wait_idle(input logic [3:0] pat);
    int cyc = 0;
    while (busy != 2'b00 && cyc < 300) begin
      ready = pat[cyc % 4];
      tick();
      cyc++;
    end
    ready = 1'b1;
    check("idle before timeout", {31'd0, busy == 2'b00}, 32'd1);
    tick();
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      check({tag, " flags"}, {27'd0, valid[k], busy[k], done[k], last[k], ovf[k]}, 32'd0);
      check({tag, " value/index"}, {16'd0, value[k], index[k]}, 32'd0);
    end
  endtask

  // Monitor: pops and compares on every transfer, checks hold on stalls and done events.
  initial begin
    logic [1:0] stall = '0;
    logic [7:0] hv [2];
    logic [7:0] hi [2];
    logic       hl [2];
    exp_t       e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (stall[k] && valid[k]) begin
          check($sformatf("hold value[%0d]", k), {24'd0, value[k]}, {24'd0, hv[k]});
          check($sformatf("hold index[%0d]", k), {24'd0, index[k]}, {24'd0, hi[k]});
          check($sformatf("hold last[%0d]", k), {31'd0, last[k]}, {31'd0, hl[k]});
        end
        if (valid[k] && ready) begin
          if (q[k].size() == 0) begin
            check($sformatf("unexpected term[%0d]", k), {24'd0, value[k]}, 32'hffff_ffff);
          end else begin
            e = q[k].pop_front();
            check($sformatf("value[%0d] idx %0d", k, e.idx), {24'd0, value[k]}, {24'd0, e.v});
            check($sformatf("index[%0d]", k), {24'd0, index[k]}, {24'd0, e.idx});
            check($sformatf("last[%0d] idx %0d", k, e.idx), {31'd0, last[k]}, {31'd0, e.last});
            check($sformatf("ovf[%0d] idx %0d", k, e.idx), {31'd0, ovf[k]}, {31'd0, e.ovf});
          end
        end
        stall[k] = valid[k] && !ready;
        hv[k] = value[k];
        hi[k] = index[k];
        hl[k] = last[k];
        if (done[k]) begin
          check($sformatf("valid at done[%0d]", k), {31'd0, valid[k]}, 32'd0);
          check($sformatf("terms left at done[%0d]", k), q[k].size(), 32'd0);
          if (dq[k].size() == 0) begin
            check($sformatf("unexpected done[%0d]", k), {31'd0, done[k]}, 32'd0);
          end else begin
            check($sformatf("ovf at done[%0d]", k), {31'd0, ovf[k]}, {31'd0, dq[k].pop_front()});
          end
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    repeat (2) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Basic run with ready held high.
    push_fib(13);
    start_seq(8'd0, 8'd1, 8'd13);
    wait_idle(4'b1111);

    // Back-pressure: ready pattern 1,0,0,1 repeating.
    push_fib(13);
    start_seq(8'd0, 8'd1, 8'd13);
    wait_idle(4'b1001);

    // count=0 start is ignored.
    start = 1'b1; seed_a = 8'd7; seed_b = 8'd7; count = 8'd0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("count0 busy/valid/done", {29'd0, busy != 0, valid != 0, done != 0}, 32'd0);
      tick();
    end

    // start during RUN is ignored.
    push_fib(13);
    start_seq(8'd0, 8'd1, 8'd13);
    tick();
    start = 1'b1; seed_a = 8'd9; seed_b = 8'd9; count = 8'd2;
    tick();
    start = 1'b0;
    wait_idle(4'b1111);

    // Overflow: stop instance ends after index 13, wrap instance carries on.
    push_fib(20);
    start_seq(8'd0, 8'd1, 8'd20);
    wait_idle(4'b1111);
    push_fib(16);
    start_seq(8'd0, 8'd1, 8'd16);
    wait_idle(4'b1111);

    // start coinciding with done is accepted.
    push_fib(5);
    start_seq(8'd0, 8'd1, 8'd5);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (done[0] !== 1'b1 && guard < 50);
    check("done seen before timeout", {31'd0, done[0]}, 32'd1);
    #1;
    push_both(8'd3, 8'd0, 1'b0);
    push_both(8'd4, 8'd1, 1'b0);
    push_both(8'd7, 8'd2, 1'b0);
    push_both(8'd11, 8'd3, 1'b1);
    dq[0].push_back(1'b0);
    dq[1].push_back(1'b0);
    start_seq(8'd3, 8'd4, 8'd4);
    wait_idle(4'b1111);

    // Asynchronous reset at index 5.
    push_fib(13);
    start_seq(8'd0, 8'd1, 8'd13);
    guard = 0;
    while (index[0] != 8'd5 && guard < 50) begin
      tick();
      guard++;
    end
    check("reached index 5", {24'd0, index[0]}, 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    for (int k = 0; k < 2; k++) begin
      q[k].delete();
      dq[k].delete();
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle after reset", {29'd0, busy != 0, valid != 0, done != 0}, 32'd0);
    end

    tick();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("terms outstanding[%0d]", k), q[k].size(), 32'd0);
      check($sformatf("dones outstanding[%0d]", k), dq[k].size(), 32'd0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
